dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the byte-addressed, 32-bit-word data memory. Requester 0 is the CPU load/store port and requester 1 is the CNN weight/activation loader. Each request is captured, checked for word alignment, and driven onto the single memory port for exactly one cycle. Read data is registered per requester and a one-cycle acknowledge is returned. The block sits directly between both requesters and the memory instance, which has a combinational read and a posedge write.

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one 32-bit data memory port
// between the CPU load/store unit (requester 0) and the CNN loader (requester 1).
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_busy,
    output logic [1:0]        o_state,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_writedata,
    output logic              o_mem_memread,
    output logic              o_mem_memwrite,
    input  logic [DATA_W-1:0] i_mem_readdata
);

    // Request handshake: a requester raises req with we/addr/wdata stable and
    // holds it until its one-cycle ack; requests are only sampled in IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_prio;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_err0;
    logic                r_err1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_win;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_misaligned;
    logic                w_load;
    logic                w_in_access;

    // Winner selection: a lone requester wins outright, a tie goes to r_prio.
    always_comb begin
        w_win = r_prio;
        if (i_req0 && !i_req1) begin
            w_win = 1'b0;
        end else if (i_req1 && !i_req0) begin
            w_win = 1'b1;
        end
    end

    assign w_win_we     = w_win ? i_we1    : i_we0;
    assign w_win_addr   = w_win ? i_addr1  : i_addr0;
    assign w_win_wdata  = w_win ? i_wdata1 : i_wdata0;
    assign w_misaligned = |w_win_addr[1:0];

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    w_load       = 1'b1;
                    w_next_state = w_misaligned ? ACK : ACCESS;
                end
            end
            ACCESS:  w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            if (w_load) begin
                r_owner <= w_win;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
                r_err   <= w_misaligned;
            end
            // Misaligned requests skip ACCESS and acknowledge straight from IDLE.
            if (w_load && w_misaligned) begin
                if (w_win) begin
                    r_ack1 <= 1'b1;
                    r_err1 <= 1'b1;
                end else begin
                    r_ack0 <= 1'b1;
                    r_err0 <= 1'b1;
                end
            end
            if (r_state == ACCESS) begin
                if (r_owner) begin
                    r_ack1 <= 1'b1;
                    r_err1 <= r_err;
                    if (!r_we) r_rdata1 <= i_mem_readdata;
                end else begin
                    r_ack0 <= 1'b1;
                    r_err0 <= r_err;
                    if (!r_we) r_rdata0 <= i_mem_readdata;
                end
            end
            if (r_state == ACK) begin
                r_prio <= ~r_owner;
            end
        end
    end

    // Reset gates the write enable so an access cut short by reset never commits.
    assign w_in_access     = (r_state == ACCESS);
    assign o_mem_address   = w_in_access ? r_addr  : '0;
    assign o_mem_writedata = w_in_access ? r_wdata : '0;
    assign o_mem_memread   = w_in_access & ~r_we;
    assign o_mem_memwrite  = w_in_access & r_we & ~i_reset;

    assign o_ack0   = r_ack0;
    assign o_ack1   = r_ack1;
    assign o_err0   = r_err0;
    assign o_err1   = r_err1;
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;
    assign o_busy   = (r_state != IDLE);
    assign o_state  = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model on the memory port.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        busy;
    logic [1:0]  state;
    logic [9:0]  mem_address;
    logic [31:0] mem_writedata;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_readdata;

    logic [7:0]  mem [0:1023];
    int          wr_cnt;
    int          errors;
    int          checks;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_err0(err0), .o_err1(err1),
        .o_rdata0(rdata0), .o_rdata1(rdata1), .o_busy(busy), .o_state(state),
        .o_mem_address(mem_address), .o_mem_writedata(mem_writedata),
        .o_mem_memread(mem_memread), .o_mem_memwrite(mem_memwrite),
        .i_mem_readdata(mem_readdata)
    );

    // Clock and memory model: combinational little-endian read, posedge write.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [9:0] ra1, ra2, ra3;
    assign ra1 = mem_address + 10'd1;
    assign ra2 = mem_address + 10'd2;
    assign ra3 = mem_address + 10'd3;
    assign mem_readdata = {mem[ra3], mem[ra2], mem[ra1], mem[mem_address]};

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem[mem_address] <= mem_writedata[7:0];
            mem[ra1]         <= mem_writedata[15:8];
            mem[ra2]         <= mem_writedata[23:16];
            mem[ra3]         <= mem_writedata[31:24];
            wr_cnt           <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [9:0] addr,
                           input logic [31:0] wdata);
        if (port == 1) begin
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One isolated request on a given port; checks every cycle of its lifetime.
    task automatic single_access(input int port, input logic we, input logic [9:0] addr,
                                 input logic [31:0] wdata, input logic exp_err,
                                 input logic [31:0] exp_rd);
        logic own_ack, oth_ack, own_err;
        logic [31:0] own_rd;
        set_req(port, we, addr, wdata);
        tick();
        if (!exp_err) begin
            check("acc_state", 32'(state), 32'd1);
            check("acc_busy", 32'(busy), 32'd1);
            check("acc_addr", 32'(mem_address), 32'(addr));
            check("acc_memwrite", 32'(mem_memwrite), 32'(we));
            check("acc_memread", 32'(mem_memread), 32'(!we));
            if (we) check("acc_wdata", mem_writedata, wdata);
            tick();
        end else begin
            check("rej_no_mem", 32'({mem_memread, mem_memwrite}), 32'd0);
        end
        own_ack = (port == 1) ? ack1 : ack0;
        oth_ack = (port == 1) ? ack0 : ack1;
        own_err = (port == 1) ? err1 : err0;
        own_rd  = (port == 1) ? rdata1 : rdata0;
        check("ack_own", 32'(own_ack), 32'd1);
        check("ack_other", 32'(oth_ack), 32'd0);
        check("err_own", 32'(own_err), 32'(exp_err));
        check("rdata_own", own_rd, exp_rd);
        check("ack_state", 32'(state), 32'd2);
        if (port == 1) req1 = 1'b0; else req0 = 1'b0;
        tick();
        check("post_ack_low", 32'({ack0, ack1}), 32'd0);
        check("post_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, req1_at, lat, wr_before;
        logic overlap;
        errors = 0; checks = 0; wr_cnt = 0;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h0D; mem[1] = 8'hF0; mem[2] = 8'hAD; mem[3] = 8'h0B;

        // Reset state
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack_err", 32'({ack0, ack1, err0, err1}), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_mem_ctl", 32'({mem_memread, mem_memwrite}), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_after_rst", 32'(state), 32'd0);

        // Single write then read on requester 0
        single_access(0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0);
        check("wr_byte13", 32'(mem[10'h013]), 32'hDE);
        check("wr_byte10", 32'(mem[10'h010]), 32'hEF);
        single_access(0, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF);
        check("rd1_untouched", rdata1, 32'd0);

        // Simultaneous requests; req0 re-raises while req1 waits
        do_reset();
        tick();
        set_req(0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b1, 10'h004, 32'h11223344);
        tick();
        check("sim1_addr", 32'(mem_address), 32'h000);
        check("sim1_memread", 32'(mem_memread), 32'd1);
        tick();
        check("sim1_ack0", 32'(ack0), 32'd1);
        check("sim1_ack1", 32'(ack1), 32'd0);
        check("sim1_rdata0", rdata0, 32'h0BADF00D);
        req0 = 1'b0;
        tick();
        check("sim1_idle", 32'(state), 32'd0);
        set_req(0, 1'b0, 10'h004, 32'h0);
        tick();
        check("sim2_addr", 32'(mem_address), 32'h004);
        check("sim2_memwrite", 32'(mem_memwrite), 32'd1);
        tick();
        check("sim2_ack1", 32'(ack1), 32'd1);
        check("sim2_ack0", 32'(ack0), 32'd0);
        check("sim2_err1", 32'(err1), 32'd0);
        req1 = 1'b0;
        tick();
        tick();
        tick();
        check("sim3_ack0", 32'(ack0), 32'd1);
        check("sim3_rdata0", rdata0, 32'h11223344);
        req0 = 1'b0;
        tick();
        check("sim_mem4", mem_word(4), 32'h11223344);

        // Starvation: req0 held for six accesses, req1 raised once
        set_req(0, 1'b0, 10'h010, 32'h0);
        n0 = 0; n1 = 0; req1_at = -1; lat = -1; overlap = 1'b0;
        for (int cyc = 0; cyc < 60 && !(n0 >= 6 && n1 >= 1); cyc++) begin
            tick();
            if (ack0 && ack1) overlap = 1'b1;
            if (ack1) begin
                n1++;
                lat = cyc - req1_at;
                req1 = 1'b0;
            end
            if (ack0) begin
                n0++;
                check("starve_rdata0", rdata0, 32'hDEADBEEF);
                if (n0 == 1) begin
                    set_req(1, 1'b1, 10'h008, 32'h77777777);
                    req1_at = cyc;
                end
                if (n0 == 6) req0 = 1'b0;
            end
        end
        tick();
        check("starve_n0", 32'(n0), 32'd6);
        check("starve_n1", 32'(n1), 32'd1);
        check("starve_lat", 32'(lat), 32'd3);
        check("starve_overlap", 32'(overlap), 32'd0);
        check("starve_mem8", mem_word(8), 32'h77777777);

        // Misaligned write from requester 1
        wr_before = wr_cnt;
        single_access(1, 1'b1, 10'h3FE, 32'hCAFEF00D, 1'b1, 32'h0);
        check("mis_no_write", 32'(wr_cnt), 32'(wr_before));
        check("mis_mem_3fe", 32'({mem[10'h3FF], mem[10'h3FE]}), 32'h0);
        set_req(0, 1'b0, 10'h010, 32'h0);
        set_req(1, 1'b0, 10'h004, 32'h0);
        tick();
        check("mis_prio_addr", 32'(mem_address), 32'h010);
        tick();
        check("mis_prio_ack0", 32'(ack0), 32'd1);
        check("mis_prio_ack1", 32'(ack1), 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        tick();
        check("mis_then_ack1", 32'(ack1), 32'd1);
        check("mis_then_rdata1", rdata1, 32'h11223344);
        req1 = 1'b0;
        tick();

        // Reset during the ACCESS cycle of a write
        wr_before = wr_cnt;
        set_req(0, 1'b1, 10'h020, 32'h55AA55AA);
        tick();
        check("rsta_state", 32'(state), 32'd1);
        check("rsta_we_pre", 32'(mem_memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rsta_we_gated", 32'(mem_memwrite), 32'd0);
        tick();
        check("rsta_idle", 32'(state), 32'd0);
        check("rsta_busy", 32'(busy), 32'd0);
        check("rsta_no_ack", 32'({ack0, ack1}), 32'd0);
        check("rsta_rdata0", rdata0, 32'd0);
        check("rsta_rdata1", rdata1, 32'd0);
        check("rsta_no_write", 32'(wr_cnt), 32'(wr_before));
        check("rsta_mem20", mem_word(32), 32'h0);
        req0 = 1'b0;
        reset = 1'b0;
        tick();

        // Upper address boundary
        single_access(0, 1'b1, 10'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0);
        check("top_mem", mem_word(10'h3FC), 32'hA5A5A5A5);
        single_access(0, 1'b0, 10'h3FC, 32'h0, 1'b0, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
